inst_rom_loader: RTL and testbench

// - Instruction-memory responder for the pipeline's fetch interface (rom_ce_o/rom_addr_o -> rom_data_i).
// - Fetch read is zero-latency and combinational, so IF/ID latches the word in the same cycle the PC presents it.
// - Adds a byte-stream program loader (valid/ready) that fills the memory at run time.
// - The core is held by the testbench/top via ld_busy_o while loading.

---
 rtl/inst_rom_loader_pkg.sv | 21 ++
 rtl/inst_rom_loader_rom_word_array.sv | 28 ++
 rtl/inst_rom_loader.sv | 154 +++++++++++++++
 tb/tb_inst_rom_loader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_loader_pkg.sv
// Shared types for the instruction ROM loader: bus widths, the NOP word and
// the loader state encoding.
package inst_rom_loader_pkg;

  localparam int INST_W      = 32;
  localparam int INST_ADDR_W = 32;

  typedef logic [INST_W-1:0]      inst_bus_t;
  typedef logic [INST_ADDR_W-1:0] inst_addr_bus_t;

  localparam inst_bus_t NOP_INST = 32'h0;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_RECV,
    LD_FLUSH,
    LD_DRAIN,
    LD_DONE
  } ld_state_e;

endpackage

// File: rtl/inst_rom_loader_rom_word_array.sv
// DEPTH x 32 instruction storage: one synchronous write port for the loader,
// one asynchronous read port so fetch sees the word in the same cycle.
module rom_word_array
  import inst_rom_loader_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  inst_bus_t     wdata_i,
  input  logic [AW-1:0] raddr_i,
  output inst_bus_t     rdata_o
);

  inst_bus_t mem_q [DEPTH];

  // NOTE: the array has no reset on purpose; a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction memory with zero-latency fetch port and a byte-stream program
// loader that assembles big-endian words and writes them from word 0 upward.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce_i,
  input  inst_addr_bus_t addr_i,
  output inst_bus_t      data_o,
  input  logic           ld_start_i,
  input  logic           ld_valid_i,
  input  logic [7:0]     ld_byte_i,
  input  logic           ld_last_i,
  output logic           ld_ready_o,
  output logic           ld_busy_o,
  output logic           ld_done_o,
  output logic           ld_err_o,
  output logic [AW:0]    ld_words_o
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  ld_state_e   state_q, state_d;
  logic [AW:0] ptr_q, ptr_d;
  logic [1:0]  cnt_q, cnt_d;
  inst_bus_t   asm_q, asm_d;
  logic        err_q, err_d;
  logic        ready_q, busy_q, done_q;

  logic        accept;
  logic        full;
  inst_bus_t   word_in;
  logic        mem_we;
  inst_bus_t   mem_wdata;
  inst_bus_t   mem_rdata;
  logic        in_range;
  logic        unused_addr_lsb;

  rom_word_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_array (
    .clk    (clk),
    .we_i   (mem_we),
    .waddr_i(ptr_q[AW-1:0]),
    .wdata_i(mem_wdata),
    .raddr_i(addr_i[AW+1:2]),
    .rdata_o(mem_rdata)
  );

  assign full = (ptr_q == DEPTH_W);

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path infers a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_wdata = asm_q;
    word_in   = asm_q;
    word_in[8*(3-int'(cnt_q)) +: 8] = ld_byte_i;
    accept    = ld_valid_i && ready_q;

    // A start anywhere but DONE begins a fresh image; any partial word is dropped.
    if (ld_start_i && state_q != LD_DONE) begin
      state_d = LD_RECV;
      ptr_d   = '0;
      cnt_d   = '0;
      asm_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        LD_RECV: begin
          if (accept) begin
            if (cnt_q == 2'd3) begin
              cnt_d = '0;
              asm_d = '0;
              if (full) begin
                err_d   = 1'b1;
                state_d = ld_last_i ? LD_DONE : LD_DRAIN;
              end else begin
                mem_we    = 1'b1;
                mem_wdata = word_in;
                ptr_d     = ptr_q + (AW+1)'(1);
                state_d   = ld_last_i ? LD_DONE : LD_RECV;
              end
            end else begin
              cnt_d = cnt_q + 2'd1;
              asm_d = word_in;
              if (ld_last_i) state_d = LD_FLUSH;
            end
          end
        end
        LD_FLUSH: begin
          // Unfilled low bytes of asm_q are still zero, which is the padding.
          if (full) begin
            err_d = 1'b1;
          end else begin
            mem_we = 1'b1;
            ptr_d  = ptr_q + (AW+1)'(1);
          end
          cnt_d   = '0;
          asm_d   = '0;
          state_d = LD_DONE;
        end
        LD_DRAIN: begin
          if (accept && ld_last_i) state_d = LD_DONE;
        end
        LD_DONE: state_d = LD_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LD_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: state uses nonblocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      err_q   <= err_d;
      ready_q <= (state_d == LD_RECV) || (state_d == LD_DRAIN);
      busy_q  <= (state_d != LD_IDLE);
      done_q  <= (state_d == LD_DONE);
    end
  end

  assign in_range        = (addr_i[31:2] < 30'(DEPTH));
  assign unused_addr_lsb = ^addr_i[1:0];
  assign data_o          = (ce_i && !busy_q && in_range) ? mem_rdata : NOP_INST;

  assign ld_ready_o = ready_q;
  assign ld_busy_o  = busy_q;
  assign ld_done_o  = done_q;
  assign ld_err_o   = err_q;
  assign ld_words_o = ptr_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Randomized bench for inst_rom_loader: a 1024-word and a 4-word instance,
// checked against an image-level model of what each load leaves in memory.
`timescale 1ns/1ps
module tb_inst_rom_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic        start, valid, last;
  logic [7:0]  bdat;
  bit          sel;

  logic        a_start, a_valid, b_start, b_valid;
  logic [31:0] a_data, b_data;
  logic        a_ready, a_busy, a_done, a_err;
  logic        b_ready, b_busy, b_done, b_err;
  logic [10:0] a_words;
  logic [2:0]  b_words;

  logic [31:0] data;
  logic        ready, busy, done, err;
  int          words;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mdl   [2][1024];
  bit          mdl_v [2][1024];

  always #5 clk = ~clk;

  assign a_start = start & ~sel;
  assign b_start = start & sel;
  assign a_valid = valid & ~sel;
  assign b_valid = valid & sel;

  inst_rom_loader #(.DEPTH(1024), .AW(10)) u_dut_a (
    .clk(clk), .rst(rst), .ce_i(ce), .addr_i(addr), .data_o(a_data),
    .ld_start_i(a_start), .ld_valid_i(a_valid), .ld_byte_i(bdat), .ld_last_i(last),
    .ld_ready_o(a_ready), .ld_busy_o(a_busy), .ld_done_o(a_done), .ld_err_o(a_err),
    .ld_words_o(a_words)
  );

  inst_rom_loader #(.DEPTH(4), .AW(2)) u_dut_b (
    .clk(clk), .rst(rst), .ce_i(ce), .addr_i(addr), .data_o(b_data),
    .ld_start_i(b_start), .ld_valid_i(b_valid), .ld_byte_i(bdat), .ld_last_i(last),
    .ld_ready_o(b_ready), .ld_busy_o(b_busy), .ld_done_o(b_done), .ld_err_o(b_err),
    .ld_words_o(b_words)
  );

  always_comb begin
    data  = sel ? b_data  : a_data;
    ready = sel ? b_ready : a_ready;
    busy  = sel ? b_busy  : a_busy;
    done  = sel ? b_done  : a_done;
    err   = sel ? b_err   : a_err;
    words = sel ? int'(b_words) : int'(a_words);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  function automatic int dep();
    return sel ? 4 : 1024;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Big-endian word w of a byte image, zero-padded past its end.
  function automatic logic [31:0] word_of(input logic [7:0] q [$], input int w);
    logic [31:0] r = '0;
    for (int k = 0; k < 4; k++)
      if (4*w + k < q.size()) r[31-8*k -: 8] = q[4*w + k];
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit l);
    int budget = 0;
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk);
      ce   = 1'b1;
      addr = {20'h0, 10'($urandom_range(0, 3)), 2'b00};
      #1 check("fetch_while_busy", data, 32'h0);
    end
    @(negedge clk);
    valid = 1'b1;
    bdat  = b;
    last  = l;
    while (!ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!ready) check("accept_timeout", 32'(ready), 32'h1);
    @(posedge clk);
    #1;
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("start_busy",  32'(busy),  32'h1);
    check("start_ready", 32'(ready), 32'h1);
    check("start_words", 32'(words), 32'h0);
    check("start_err",   32'(err),   32'h0);
  endtask

  task automatic verify_mem();
    int d = dep();
    for (int w = 0; w < d; w++) begin
      if (mdl_v[sel][w]) begin
        @(negedge clk);
        ce   = 1'b1;
        addr = {w[29:0], 2'($urandom_range(0, 3))};
        #1 check($sformatf("fetch_w%0d", w), data, mdl[sel][w]);
      end
    end
    @(negedge clk);
    ce   = 1'b1;
    addr = 32'(d * 4);
    #1 check("fetch_out_of_range", data, 32'h0);
    ce   = 1'b0;
    addr = 32'h0;
    #1 check("fetch_ce_low", data, 32'h0);
  endtask

  task automatic run_load(input logic [7:0] img [$], input int junk_n);
    int n  = img.size();
    int nw = (n + 3) / 4;
    int d  = dep();
    int exp_lat, lat, dones;
    bit rdy_seen;
    logic [7:0] junk [$];

    start_pulse();
    if (junk_n > 0) begin
      for (int i = 0; i < junk_n; i++) begin
        junk.push_back(8'($urandom));
        send_byte(junk[i], 1'b0);
      end
      for (int w = 0; w < imin(junk_n / 4, d); w++) begin
        mdl[sel][w]   = word_of(junk, w);
        mdl_v[sel][w] = 1'b1;
      end
      @(negedge clk);
      check("junk_err",   32'(err),   32'((junk_n / 4) > d));
      check("junk_words", 32'(words), 32'(imin(junk_n / 4, d)));
      start_pulse();
    end

    for (int i = 0; i < n; i++) send_byte(img[i], i == n - 1);

    // A trailing partial word costs one flush cycle unless the image already overflowed.
    exp_lat  = ((n % 4) != 0 && (n / 4) <= d) ? 2 : 1;
    lat      = 0;
    dones    = 0;
    rdy_seen = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      valid = 1'b1;
      bdat  = 8'($urandom);
      #1;
      rdy_seen |= ready;
      if (done) begin
        dones++;
        if (lat == 0) lat = c;
      end
    end
    valid = 1'b0;
    check("done_pulses",   32'(dones),    32'h1);
    check("done_latency",  32'(lat),      32'(exp_lat));
    check("ready_low_end", 32'(rdy_seen), 32'h0);
    check("busy_after",    32'(busy),     32'h0);
    check("err_after",     32'(err),      32'(nw > d));
    check("words_after",   32'(words),    32'(imin(nw, d)));

    for (int w = 0; w < imin(nw, d); w++) begin
      mdl[sel][w]   = word_of(img, w);
      mdl_v[sel][w] = 1'b1;
    end
    verify_mem();
  endtask

  task automatic rand_img(output logic [7:0] q [$], input int n);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endtask

  initial begin
    logic [7:0]  img [$];
    logic [31:0] pre [4];
    logic [7:0]  rb  [5];

    rst   = 1'b0;
    ce    = 1'b0;
    addr  = '0;
    start = 1'b0;
    valid = 1'b0;
    last  = 1'b0;
    bdat  = '0;
    sel   = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 1024; w++) mdl_v[s][w] = 1'b0;

    #2;
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_done",  32'(done),  32'h0);
    check("rst_err",   32'(err),   32'h0);
    check("rst_words", 32'(words), 32'h0);
    check("rst_data",  data,       32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Boot program, then fetch words 0 and 1.
    pre = '{32'h34010005, 32'h34020003, 32'h0, 32'h0};
    img = {};
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 4; k++) img.push_back(pre[w][31-8*k -: 8]);
    run_load(img, 0);
    @(negedge clk);
    ce = 1'b1; addr = 32'h0;
    #1 check("boot_addr0", data, 32'h34010005);
    addr = 32'h4;
    #1 check("boot_addr4", data, 32'h34020003);

    img = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_load(img, 0);

    img = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    run_load(img, 0);
    @(negedge clk);
    ce = 1'b1; addr = 32'h4;
    #1 check("flush_word1", data, 32'hEEFF0000);

    // Small instance: exact fill, overflow on last byte, drain, overflow in flush.
    sel = 1'b1;
    rand_img(img, 16); run_load(img, 0);
    rand_img(img, 20); run_load(img, 0);
    rand_img(img, 23); run_load(img, 0);
    rand_img(img, 18); run_load(img, 0);

    // Asynchronous reset part-way through the second word.
    sel = 1'b0;
    start_pulse();
    for (int i = 0; i < 5; i++) begin
      rb[i] = 8'($urandom);
      send_byte(rb[i], 1'b0);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_ready", 32'(ready), 32'h0);
    check("arst_busy",  32'(busy),  32'h0);
    check("arst_done",  32'(done),  32'h0);
    check("arst_err",   32'(err),   32'h0);
    check("arst_words", 32'(words), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    mdl[0][0] = {rb[0], rb[1], rb[2], rb[3]};
    verify_mem();
    rand_img(img, 9); run_load(img, 0);

    // Restart mid-load, including from an overflowed drain.
    rand_img(img, 10); run_load(img, 6);
    sel = 1'b1;
    rand_img(img, 8);  run_load(img, 21);

    for (int it = 0; it < 8; it++) begin
      sel = 1'($urandom_range(0, 1));
      rand_img(img, sel ? $urandom_range(1, 26) : $urandom_range(1, 40));
      run_load(img, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 22) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
